excess3_to_bcd_seq: RTL and testbench

//   Multi-digit Excess-3 to BCD decoder, the return path for packed Excess-3 words.

---
 rtl/excess3_to_bcd_seq_if.sv | 24 ++
 rtl/excess3_to_bcd_seq.sv | 98 +++++++++
 tb/tb_excess3_to_bcd_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/excess3_to_bcd_seq_if.sv
// Handshake bundle for the Excess-3 to BCD decoder: word in, packed BCD and error mask out.
// The producer/consumer side drives the master modport; the decoder uses the slave modport.
interface excess3_to_bcd_seq_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_code;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  out_err;
  logic [DIGITS-1:0]     out_err_mask;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_bcd, out_err, out_err_mask
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_bcd, out_err, out_err_mask
  );
endinterface

// File: rtl/excess3_to_bcd_seq.sv
// Sequential multi-digit Excess-3 to BCD decoder: accepts one packed word, converts one
// digit per clock (LSD first), then holds the BCD word and per-digit error mask until taken.
module excess3_to_bcd_seq #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  excess3_to_bcd_seq_if.slave   bus
);
  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [W-1:0]       cap_q;
  logic [W-1:0]       bcd_q;
  logic [DIGITS-1:0]  mask_q;
  logic               err_q;

  logic               accept;
  logic               last_digit;
  logic [3:0]         cur_code;
  logic [3:0]         cur_bcd;
  logic               cur_illegal;

  // Digit currently being decoded; legal Excess-3 codes are 3..12.
  always_comb begin
    cur_code    = cap_q[4*int'(cnt_q) +: 4];
    cur_illegal = (cur_code < 4'd3) || (cur_code > 4'd12);
    cur_bcd     = cur_illegal ? 4'h0 : (cur_code - 4'd3);
    last_digit  = (cnt_q == CNT_W'(DIGITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        if (last_digit) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the capture and result registers are reset as well, so an aborted word never
  // leaks onto out_bcd; state updates use non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      cap_q  <= '0;
      bcd_q  <= '0;
      mask_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      cnt_q  <= '0;
      cap_q  <= bus.in_code;
      bcd_q  <= '0;
      mask_q <= '0;
      err_q  <= 1'b0;
    end else if (state_q == CONV) begin
      bcd_q[4*int'(cnt_q) +: 4] <= cur_bcd;
      mask_q[cnt_q]             <= cur_illegal;
      err_q                     <= err_q | cur_illegal;
      if (!last_digit) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Results stay in registers after DONE so they hold once out_valid drops.
  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.out_bcd      = bcd_q;
  assign bus.out_err      = err_q;
  assign bus.out_err_mask = mask_q;
endmodule

// File: tb/tb_excess3_to_bcd_seq.sv
// Directed bench for excess3_to_bcd_seq (DIGITS=4); inputs driven and outputs sampled on
// the falling clock edge, expected values hand-computed from the Excess-3 code table.
module tb_excess3_to_bcd_seq;
  localparam int DIGITS = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  excess3_to_bcd_seq_if #(.DIGITS(DIGITS)) bus ();

  excess3_to_bcd_seq #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a word for one cycle, wait for out_valid, check result and the return to IDLE.
  // Cycle count starts at the presenting cycle, so the expected latency is DIGITS+1.
  task automatic run_word(input string tag, input logic [15:0] code,
                          input logic [15:0] exp_bcd, input logic [3:0] exp_mask);
    int cycles;
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_code  = code;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    cycles = 1;
    while (!bus.out_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, ".latency"}, 32'(cycles), 32'(DIGITS + 1));
    check({tag, ".bcd"},     32'(bus.out_bcd), 32'(exp_bcd));
    check({tag, ".mask"},    32'(bus.out_err_mask), 32'(exp_mask));
    check({tag, ".err"},     32'(bus.out_err), 32'(|exp_mask));
    if (bus.out_ready) begin
      @(negedge clk);
      check({tag, ".idle_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, ".idle_ready"}, 32'(bus.in_ready), 32'd1);
      check({tag, ".held_bcd"},   32'(bus.out_bcd), 32'(exp_bcd));
    end
  endtask

  logic [15:0] b2b_code [3];
  logic [15:0] b2b_exp  [3];

  initial begin
    int sent;
    int rcv;
    int last_t;
    n_cmp = 0;
    n_bad = 0;
    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst.in_ready",  32'(bus.in_ready), 32'd1);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.out_bcd",   32'(bus.out_bcd), 32'd0);
    check("rst.out_err",   32'(bus.out_err), 32'd0);
    check("rst.mask",      32'(bus.out_err_mask), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Legal words
    run_word("e3_0123", 16'h3456, 16'h0123, 4'b0000);
    run_word("e3_9090", 16'hC3C3, 16'h9090, 4'b0000);
    run_word("e3_0000", 16'h3333, 16'h0000, 4'b0000);

    // Illegal digits
    run_word("ill_hi",  16'h2F35, 16'h0002, 4'b1100);
    run_word("ill_all", 16'h0000, 16'h0000, 4'b1111);

    // Backpressure: result held, in_ready low, extra in_valid ignored
    bus.out_ready = 1'b0;
    run_word("bp", 16'h4C7A, 16'h1947, 4'b0000);
    bus.in_code  = 16'h3456;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp.out_valid", 32'(bus.out_valid), 32'd1);
      check("bp.out_bcd",   32'(bus.out_bcd), 32'h1947);
      check("bp.in_ready",  32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp.release_valid", 32'(bus.out_valid), 32'd0);
    check("bp.release_ready", 32'(bus.in_ready), 32'd1);
    check("bp.release_bcd",   32'(bus.out_bcd), 32'h1947);

    // Async reset during the second conversion cycle discards the word
    bus.in_code  = 16'h5555;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst.out_bcd",   32'(bus.out_bcd), 32'd0);
    check("mid_rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst.mask",      32'(bus.out_err_mask), 32'd0);
    check("mid_rst.in_ready",  32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst.after_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst.no_valid",    32'(bus.out_valid), 32'd0);
    run_word("post_rst", 16'h3C48, 16'h0915, 4'b0000);

    // Back-to-back with in_valid held high: one result every DIGITS+2 cycles, in order
    b2b_code[0] = 16'h4567; b2b_exp[0] = 16'h1234;
    b2b_code[1] = 16'hCBA9; b2b_exp[1] = 16'h9876;
    b2b_code[2] = 16'h3C3C; b2b_exp[2] = 16'h0909;
    sent   = 0;
    rcv    = 0;
    last_t = 0;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 60 && rcv < 3; t++) begin
      if (bus.out_valid) begin
        check("b2b.bcd", 32'(bus.out_bcd), 32'(b2b_exp[rcv]));
        if (rcv > 0) check("b2b.spacing", 32'(t - last_t), 32'(DIGITS + 2));
        last_t = t;
        rcv++;
      end
      if (bus.in_ready) begin
        if (sent < 3) begin
          bus.in_code = b2b_code[sent];
          sent++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("b2b.count", 32'(rcv), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
